// File: rtl/shift_pkg.sv
// Shared types and encodings for the shift sequencer and its step unit.
package shift_pkg;

    localparam logic [1:0] MODE_LOGIC  = 2'b00;
    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROT    = 2'b10;
    localparam logic [1:0] MODE_SERIAL = 2'b11;

    typedef enum logic [1:0] {
        LOGIC  = MODE_LOGIC,
        ARITH  = MODE_ARITH,
        ROT    = MODE_ROT,
        SERIAL = MODE_SERIAL
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of k bits (0..STEP) with mode-dependent fill
// and the last bit that leaves the word.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [KW-1:0]    k_i,
    input  logic             dir_i,
    input  shift_mode_t      mode_i,
    input  logic [STEP-1:0]  serial_i,
    output logic [WIDTH-1:0] data_o,
    output logic             exit_o
);

    logic [STEP-1:0]       serial_rev;
    logic [STEP-1:0]       fill;
    logic [WIDTH+STEP-1:0] left_ext;
    logic [WIDTH+STEP-1:0] right_ext;
    logic [KW-1:0]         k_m1;
    logic [WIDTH-1:0]      left_probe;
    logic [WIDTH-1:0]      right_probe;

    // On a left shift serial bit 0 must land highest in the vacated field,
    // so the entering nibble is bit-reversed.
    for (genvar gi = 0; gi < STEP; gi++) begin : g_rev
        assign serial_rev[gi] = serial_i[STEP-1-gi];
    end

    // Fill field is laid out so the top (left) or bottom (right) k bits of it
    // are what a k-bit shift pulls in, independent of k.
    always_comb begin
        fill = '0;
        case (mode_i)
            ROT:     fill = dir_i ? data_i[STEP-1:0] : data_i[WIDTH-1 -: STEP];
            SERIAL:  fill = dir_i ? serial_i : serial_rev;
            ARITH:   if (dir_i) fill = {STEP{data_i[WIDTH-1]}};
            default: fill = '0;
        endcase
    end

    // Shift through the extended word; the exiting bit is probed at k-1.
    always_comb begin
        left_ext    = {data_i, fill} << k_i;
        right_ext   = {fill, data_i} >> k_i;
        k_m1        = (k_i == '0) ? '0 : k_i - KW'(1);
        left_probe  = data_i << k_m1;
        right_probe = data_i >> k_m1;
        data_o      = dir_i ? right_ext[WIDTH-1:0] : left_ext[WIDTH+STEP-1:STEP];
        exit_o      = dir_i ? right_probe[0] : left_probe[WIDTH-1];
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: moves up to STEP bits per cycle with a
// start/busy/done handshake and a carry holding the last bit shifted out.
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             start,
    input  logic [CNTW-1:0]  amount,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [STEP-1:0]  serial_in,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  serial_out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int KW = $clog2(STEP + 1);

    shift_state_t     state_q, state_d;
    logic [CNTW-1:0]  rem_q, rem_d;
    logic             dir_q, dir_d;
    shift_mode_t      mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             carry_q, carry_d;

    logic [KW-1:0]    step_k;
    logic [WIDTH-1:0] step_data;
    logic             step_exit;
    logic             eff_dir;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data_i   (q_q),
        .k_i      (step_k),
        .dir_i    (dir_q),
        .mode_i   (mode_q),
        .serial_i (serial_in),
        .data_o   (step_data),
        .exit_o   (step_exit)
    );

    // Step size is a full STEP except for a trailing partial step.
    always_comb begin
        if (rem_q < CNTW'(STEP)) step_k = KW'(rem_q);
        else                     step_k = KW'(STEP);
    end

    // Next-state logic: load/start only in IDLE, load wins over start.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        q_d     = q_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    q_d = parallel_in;
                end else if (start) begin
                    dir_d   = dir;
                    mode_d  = shift_mode_t'(mode);
                    rem_d   = (amount > CNTW'(WIDTH)) ? CNTW'(WIDTH) : amount;
                    state_d = (amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                q_d     = step_data;
                carry_d = step_exit;
                rem_d   = rem_q - CNTW'(step_k);
                if (rem_q <= CNTW'(STEP)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= LOGIC;
            q_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    assign eff_dir    = (state_q == SHIFT) ? dir_q : dir;
    assign serial_out = eff_dir ? q_q[STEP-1:0] : q_q[WIDTH-1 -: STEP];
    assign q          = q_q;
    assign carry      = carry_q;
    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle, parametrised shift sequencer for the bit-serial datapath.
- Performs a shift of a requested amount, 0..WIDTH, in ceil(amount/STEP) cycles, moving STEP bits per cycle.
- Modes: logical, arithmetic, rotate and serial-fill.
- Uses a start/busy/done handshake and a registered carry that holds the last bit shifted out.
- Serves as the shift unit and carry source for the CPU ALU and operand streaming.

Parameters:
- WIDTH, 16, register width in bits; must be at least 2.
- STEP, 4, bits shifted per active cycle; must be at least 1 and must divide WIDTH.
- CNTW, $clog2(WIDTH+1), width of the amount and remaining-count fields.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- load  in  1  parallel load of q from parallel_in; honoured in IDLE only.
- parallel_in  in  WIDTH  parallel load data.
- start  in  1  begin a shift operation; honoured in IDLE only.
- amount  in  CNTW  shift distance, sampled on an accepted start.
- dir  in  1  0 = left, 1 = right; sampled on an accepted start.
- mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 serial; sampled on an accepted start.
- serial_in  in  STEP  fill bits for serial mode, consumed live each SHIFT cycle.
- q  out  WIDTH  register contents.
- serial_out  out  STEP  the STEP bits at the exiting edge of q.
- carry  out  1  last bit shifted out by the most recent nonzero operation.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse when an operation completes.

Behaviour:
- Reset (rstn low, asynchronous, takes effect without a clock edge):
  - q = 0, carry = 0, busy = 0, done = 0.
  - State = IDLE; latched dir, mode and remaining count = 0.
- States:
  - IDLE to SHIFT on an accepted start with amount != 0.
  - IDLE to DONE on an accepted start with amount == 0.
  - SHIFT to DONE when remaining reaches 0.
  - DONE to IDLE unconditionally after one cycle.
- done is registered and is high exactly during the DONE cycle.
- busy = (state == SHIFT).
- Priority in IDLE: load beats start. If both are high, q loads and start is dropped.
- In SHIFT or DONE, load and start are ignored.
- On accepted start:
  - Latch dir and mode.
  - remaining = min(amount, WIDTH); amounts above WIDTH clamp to WIDTH.
- Each SHIFT cycle:
  - k = min(STEP, remaining); shift q by k; remaining -= k.
  - The last active cycle has k = remaining mod STEP when nonzero, and may therefore be a partial step.
- Fill bits for the vacated k positions:
  - Logical: zeros.
  - Arithmetic: q[WIDTH-1] on a right shift; zeros on a left shift (identical to logical).
  - Rotate: the bits shifted out, re-entering at the opposite end.
  - Serial: serial_in[k-1:0]. Bit 0 enters first, so bit 0 ends farthest from the entry edge.
- carry updates on every SHIFT cycle to the last bit exiting in that cycle.
  - For a left shift this is q[WIDTH-k]; for a right shift it is q[k-1].
  - Net effect: carry equals the last bit out of the whole operation.
  - carry is unchanged by load and by amount == 0.
- serial_out is combinational from q:
  - q[WIDTH-1 -: STEP] when the effective direction is 0, else q[STEP-1:0].
  - Effective direction is the latched dir while busy, otherwise the dir input.
- Latency: done is asserted ceil(min(amount, WIDTH)/STEP) + 1 cycles after the start edge. For amount == 0 it is asserted 1 cycle after.
- Throughput: a new start can be accepted in the cycle after DONE.

Decomposition:
- shift_pkg holds:
  - enum shift_mode_t: LOGIC, ARITH, ROT, SERIAL.
  - enum shift_state_t: IDLE, SHIFT, DONE.
  - Constants for the mode encodings.
- Sub-module shift_step: a combinational shift of one step by k (0..STEP) with direction, mode fill and exiting-bit outputs.
  - Reused later by the ALU. The sequencer instantiates one copy.

Test Plan (WIDTH=16, STEP=4):
- Reset: pulse rstn low with no clock edge -> q = 0x0000, carry = 0, busy = 0, done = 0 immediately.
- Logical left: load 0x8421; start amount = 5, dir = 0, mode = 00 -> busy for 2 cycles, done in cycle 3, q = 0x8420, carry = 0.
- Arithmetic right: load 0x8000; start amount = 3, dir = 1, mode = 01 -> 1 busy cycle, q = 0xF000, carry = 0.
- Rotate left with clamping: load 0x8421; start amount = 16, dir = 0, mode = 10 -> 4 busy cycles, q = 0x8421, carry = 1.
  - Repeat with amount = 20 -> same result (clamped).
- Edge cases:
  - amount = 0 -> done the next cycle, q and carry unchanged.
  - load and start in the same IDLE cycle -> q = parallel_in, no operation starts.
  - start or load while busy -> ignored, result unaffected.
- Serial fill and mid-operation reset:
  - Load 0x0000; start amount = 8, dir = 1, mode = 11, serial_in = 0xA then 0x5 -> q = 0x5A00.
  - Repeat and drop rstn during cycle 1 of SHIFT -> q = 0, busy = 0 asynchronously, no done pulse.
